// File: rtl/wrr_pkg.sv
// ---------------------------------------------------------------------------
// wrr_pkg
// Shared constants, the arbiter state type and a pointer helper for the
// weighted round-robin arbiter and its rotating-priority picker.
// No ports (package).
// ---------------------------------------------------------------------------
package wrr_pkg;

    localparam int N     = 4;
    localparam int SEL_W = 2;
    localparam int Q_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Advance a port index by one, wrapping from the last port back to 0.
    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] idx);
        return (idx == SEL_W'(N - 1)) ? '0 : idx + SEL_W'(1);
    endfunction

endpackage

// File: rtl/wrr_arbiter_if.sv
// ---------------------------------------------------------------------------
// wrr_arbiter_if
// Bundles the FIFO-side and mux-side signals of the arbiter.
//   request   : bit i = FIFO i non-empty
//   quantum   : port i burst length in bits [i*Q_W +: Q_W]
//   down_full : downstream almost-full, stalls popping
//   pop       : one-hot read strobe to the FIFOs
//   port_sel  : mux select for the word on the mux this cycle
//   valid_mux : mux output is valid
// The slave modport is the arbiter's view; master is the environment's.
// ---------------------------------------------------------------------------
interface wrr_arbiter_if;
    import wrr_pkg::*;

    logic [N-1:0]     request;
    logic [N*Q_W-1:0] quantum;
    logic             down_full;
    logic [N-1:0]     pop;
    logic [SEL_W-1:0] port_sel;
    logic             valid_mux;

    modport master (
        output request, quantum, down_full,
        input  pop, port_sel, valid_mux
    );

    modport slave (
        input  request, quantum, down_full,
        output pop, port_sel, valid_mux
    );

endinterface

// File: rtl/rr_priority_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
// Combinational rotating-priority encoder: returns the first set request
// bit scanning ptr, ptr+1, ... modulo N.
//   request : in  N     request vector
//   ptr     : in  SEL_W highest-priority index
//   any     : out 1     at least one request bit set
//   idx     : out SEL_W chosen index (0 when none set)
// ---------------------------------------------------------------------------
module rr_priority_pick
    import wrr_pkg::*;
(
    input  logic [N-1:0]     request,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic             w_found;
    logic [SEL_W-1:0] w_cand;

    // Walk the ports starting at the pointer; index arithmetic wraps
    // naturally because N is a power of two. The first hit wins.
    always_comb begin
        any     = |request;
        idx     = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = ptr + SEL_W'(k);
            if (!w_found && request[w_cand]) begin
                idx     = w_cand;
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wrr_arbiter.sv
// ---------------------------------------------------------------------------
// wrr_arbiter
// Weighted round-robin controller sharing one 4x1 output mux between four
// input FIFOs. A grant pops the chosen FIFO for up to its quantum words;
// one IDLE cycle separates consecutive grants.
//   clk   : in  1  rising-edge clock
//   reset : in  1  synchronous, active-high reset
//   bus   : slave modport of wrr_arbiter_if (request/quantum/down_full in,
//           pop/port_sel/valid_mux out)
// ---------------------------------------------------------------------------
module wrr_arbiter
    import wrr_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    wrr_arbiter_if.slave  bus
);

    state_t           r_state, w_nextState;
    logic [SEL_W-1:0] r_ptr, w_nextPtr;
    logic [SEL_W-1:0] r_gnt, w_nextGnt;
    logic [Q_W-1:0]   r_cnt, w_nextCnt;
    logic [SEL_W-1:0] r_portSel;
    logic             r_validMux;

    logic             w_any;
    logic [SEL_W-1:0] w_pickIdx;
    logic [Q_W-1:0]   w_quanta [N];
    logic [Q_W-1:0]   w_loadCnt;
    logic             w_popNow;
    logic [N-1:0]     w_pop;
    logic             w_burstEnd;

    for (genvar i = 0; i < N; i++) begin : g_quanta
        assign w_quanta[i] = bus.quantum[i*Q_W +: Q_W];
    end

    rr_priority_pick u_pick (
        .request (bus.request),
        .ptr     (r_ptr),
        .any     (w_any),
        .idx     (w_pickIdx)
    );

    // Pop strobe is purely combinational so that down_full and reset can
    // suppress it within the very cycle they are asserted.
    always_comb begin
        w_popNow = (r_state == GRANT) && bus.request[r_gnt] &&
                   !bus.down_full && !reset;
        w_pop    = '0;
        if (w_popNow) begin
            w_pop[r_gnt] = 1'b1;
        end
    end

    // A burst ends on its last word or when the granted FIFO runs dry;
    // both together still count as a single end.
    always_comb begin
        w_burstEnd = (r_state == GRANT) &&
                     ((w_popNow && (r_cnt == Q_W'(1))) || !bus.request[r_gnt]);
        w_loadCnt  = (w_quanta[w_pickIdx] == '0) ? Q_W'(1) : w_quanta[w_pickIdx];
    end

    // Next-state logic: IDLE picks a port and samples its quantum, GRANT
    // counts words down and hands the pointer to the next port at the end.
    always_comb begin
        w_nextState = r_state;
        w_nextPtr   = r_ptr;
        w_nextGnt   = r_gnt;
        w_nextCnt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_any && !bus.down_full) begin
                    w_nextState = GRANT;
                    w_nextGnt   = w_pickIdx;
                    w_nextCnt   = w_loadCnt;
                end
            end
            GRANT: begin
                if (w_popNow) begin
                    w_nextCnt = r_cnt - Q_W'(1);
                end
                if (w_burstEnd) begin
                    w_nextState = IDLE;
                    w_nextPtr   = next_ptr(r_gnt);
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // State registers plus the read-pipeline stage: the mux sees the FIFO
    // word one cycle after the pop, so select/valid are delayed copies.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_gnt      <= '0;
            r_cnt      <= '0;
            r_portSel  <= '0;
            r_validMux <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_ptr      <= w_nextPtr;
            r_gnt      <= w_nextGnt;
            r_cnt      <= w_nextCnt;
            r_validMux <= |w_pop;
            if (|w_pop) begin
                r_portSel <= r_gnt;
            end
        end
    end

    assign bus.pop       = w_pop;
    assign bus.port_sel  = r_portSel;
    assign bus.valid_mux = r_validMux;

endmodule

// File: tb/tb_wrr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wrr_arbiter
// Directed, self-checking bench for wrr_arbiter. Inputs change on the
// falling edge; outputs are sampled 1 time unit later, well away from the
// rising (active) edge. Expected values are hand-computed per step.
// ---------------------------------------------------------------------------
module tb_wrr_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    wrr_arbiter_if bus();

    wrr_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle's inputs just after the falling edge, then let the
    // combinational pop settle before anything is sampled.
    task automatic applyStimulus(input logic [3:0] req, input logic df,
                                 input logic rst);
        @(negedge clk);
        bus.request   = req;
        bus.down_full = df;
        reset         = rst;
        #1;
    endtask

    // Compare the three DUT outputs against hand-computed values.
    task automatic checkOutput(input string tag, input logic [3:0] expPop,
                               input logic expValid, input logic [1:0] expSel);
        checks++;
        assert (bus.pop === expPop)
        else begin
            failures++;
            $error("[TB] FAIL %s pop: got %b expected %b", tag, bus.pop, expPop);
        end
        checks++;
        assert (bus.valid_mux === expValid)
        else begin
            failures++;
            $error("[TB] FAIL %s valid_mux: got %b expected %b", tag, bus.valid_mux, expValid);
        end
        checks++;
        assert (bus.port_sel === expSel)
        else begin
            failures++;
            $error("[TB] FAIL %s port_sel: got %0d expected %0d", tag, bus.port_sel, expSel);
        end
    endtask

    // Directed sequence; quantum is packed as {q3, q2, q1, q0}.
    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        bus.request   = 4'b0000;
        bus.down_full = 1'b0;
        bus.quantum   = {3'd0, 3'd3, 3'd2, 3'd1};

        // Reset held with all ports requesting
        applyStimulus(4'b1111, 1'b0, 1'b1); checkOutput("rst1", 4'b0000, 1'b0, 2'd0);
        applyStimulus(4'b1111, 1'b0, 1'b1); checkOutput("rst2", 4'b0000, 1'b0, 2'd0);

        // Fairness and weights: P0x1, P1x2, P2x3, P3x1 (quantum 0 -> 1)
        applyStimulus(4'b1111, 1'b0, 1'b0); checkOutput("idle0", 4'b0000, 1'b0, 2'd0);
        applyStimulus(4'b1111, 1'b0, 1'b0); checkOutput("p0_w1", 4'b0001, 1'b0, 2'd0);
        applyStimulus(4'b1111, 1'b0, 1'b0); checkOutput("bub01", 4'b0000, 1'b1, 2'd0);
        applyStimulus(4'b1111, 1'b0, 1'b0); checkOutput("p1_w1", 4'b0010, 1'b0, 2'd0);
        applyStimulus(4'b1111, 1'b0, 1'b0); checkOutput("p1_w2", 4'b0010, 1'b1, 2'd1);
        applyStimulus(4'b1111, 1'b0, 1'b0); checkOutput("bub12", 4'b0000, 1'b1, 2'd1);
        applyStimulus(4'b1111, 1'b0, 1'b0); checkOutput("p2_w1", 4'b0100, 1'b0, 2'd1);
        applyStimulus(4'b1111, 1'b0, 1'b0); checkOutput("p2_w2", 4'b0100, 1'b1, 2'd2);
        applyStimulus(4'b1111, 1'b0, 1'b0); checkOutput("p2_w3", 4'b0100, 1'b1, 2'd2);
        applyStimulus(4'b1111, 1'b0, 1'b0); checkOutput("bub23", 4'b0000, 1'b1, 2'd2);
        applyStimulus(4'b1111, 1'b0, 1'b0); checkOutput("p3_w1", 4'b1000, 1'b0, 2'd2);
        applyStimulus(4'b1111, 1'b0, 1'b0); checkOutput("bub30", 4'b0000, 1'b1, 2'd3);
        applyStimulus(4'b1111, 1'b0, 1'b0); checkOutput("wrap_p0", 4'b0001, 1'b0, 2'd3);

        // Single requester on port 1 with quantum 3, re-granted after a bubble
        applyStimulus(4'b0010, 1'b0, 1'b0);
        bus.quantum = {3'd0, 3'd3, 3'd3, 3'd1};
        checkOutput("single_idle", 4'b0000, 1'b1, 2'd0);
        applyStimulus(4'b0010, 1'b0, 1'b0); checkOutput("s_a1", 4'b0010, 1'b0, 2'd0);
        applyStimulus(4'b0010, 1'b0, 1'b0); checkOutput("s_a2", 4'b0010, 1'b1, 2'd1);
        applyStimulus(4'b0010, 1'b0, 1'b0); checkOutput("s_a3", 4'b0010, 1'b1, 2'd1);
        applyStimulus(4'b0010, 1'b0, 1'b0); checkOutput("s_bub", 4'b0000, 1'b1, 2'd1);
        applyStimulus(4'b0010, 1'b0, 1'b0); checkOutput("s_b1", 4'b0010, 1'b0, 2'd1);

        // Backpressure mid-burst: four stalled cycles, then the remaining two
        applyStimulus(4'b0010, 1'b1, 1'b0); checkOutput("stall1", 4'b0000, 1'b1, 2'd1);
        applyStimulus(4'b0010, 1'b1, 1'b0); checkOutput("stall2", 4'b0000, 1'b0, 2'd1);
        applyStimulus(4'b0010, 1'b1, 1'b0); checkOutput("stall3", 4'b0000, 1'b0, 2'd1);
        applyStimulus(4'b0010, 1'b1, 1'b0); checkOutput("stall4", 4'b0000, 1'b0, 2'd1);
        applyStimulus(4'b0010, 1'b0, 1'b0); checkOutput("s_b2", 4'b0010, 1'b0, 2'd1);
        applyStimulus(4'b0010, 1'b0, 1'b0); checkOutput("s_b3", 4'b0010, 1'b1, 2'd1);

        // Early empty: port 2 with quantum 5 drains after two words
        applyStimulus(4'b0100, 1'b0, 1'b0);
        bus.quantum = {3'd0, 3'd5, 3'd3, 3'd1};
        checkOutput("ee_idle", 4'b0000, 1'b1, 2'd1);
        applyStimulus(4'b0100, 1'b0, 1'b0); checkOutput("ee_w1", 4'b0100, 1'b0, 2'd1);
        applyStimulus(4'b0100, 1'b0, 1'b0); checkOutput("ee_w2", 4'b0100, 1'b1, 2'd2);
        applyStimulus(4'b1000, 1'b0, 1'b0); checkOutput("ee_empty", 4'b0000, 1'b1, 2'd2);

        // Port 3 is next; give it quantum 2 and reset in its second word
        applyStimulus(4'b1000, 1'b0, 1'b0);
        bus.quantum = {3'd2, 3'd5, 3'd3, 3'd1};
        checkOutput("p3_idle", 4'b0000, 1'b0, 2'd2);
        applyStimulus(4'b1000, 1'b0, 1'b0); checkOutput("p3_w1", 4'b1000, 1'b0, 2'd2);
        applyStimulus(4'b1111, 1'b0, 1'b1); checkOutput("rst_mid", 4'b0000, 1'b1, 2'd3);
        applyStimulus(4'b1111, 1'b0, 1'b0); checkOutput("post_rst", 4'b0000, 1'b0, 2'd0);
        applyStimulus(4'b1111, 1'b0, 1'b0); checkOutput("post_p0", 4'b0001, 1'b0, 2'd0);

        // down_full in IDLE holds off the next grant
        applyStimulus(4'b1111, 1'b1, 1'b0); checkOutput("idle_df", 4'b0000, 1'b1, 2'd0);
        applyStimulus(4'b1111, 1'b0, 1'b0); checkOutput("idle_rel", 4'b0000, 1'b0, 2'd0);
        applyStimulus(4'b1111, 1'b0, 1'b0); checkOutput("after_df", 4'b0010, 1'b0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
